// File: rtl/input_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// input_pkg
// Shared constants for the arcade input controller: joystick bit positions,
// PS/2 scancodes for both players and a scancode decoder that maps a code
// onto (player, joystick bit). Keyboard flags are stored in the same bit
// layout as the joystick words so that the two can simply be ORed.
// ---------------------------------------------------------------------------
package input_pkg;

    localparam int JOY_W = 11;

    // Joystick word bit positions (same for both players)
    localparam logic [3:0] JB_RIGHT   = 4'd0;
    localparam logic [3:0] JB_LEFT    = 4'd1;
    localparam logic [3:0] JB_DOWN    = 4'd2;
    localparam logic [3:0] JB_UP      = 4'd3;
    localparam logic [3:0] JB_B1      = 4'd4;
    localparam logic [3:0] JB_B2      = 4'd5;
    localparam logic [3:0] JB_B3      = 4'd6;
    localparam logic [3:0] JB_START   = 4'd7;
    localparam logic [3:0] JB_COIN    = 4'd8;
    localparam logic [3:0] JB_PAUSE   = 4'd9;
    localparam logic [3:0] JB_SERVICE = 4'd10;

    // Player 1 scancodes
    localparam logic [7:0] SC_P1_UP      = 8'h75;
    localparam logic [7:0] SC_P1_DOWN    = 8'h72;
    localparam logic [7:0] SC_P1_LEFT    = 8'h6B;
    localparam logic [7:0] SC_P1_RIGHT   = 8'h74;
    localparam logic [7:0] SC_P1_B1      = 8'h14;
    localparam logic [7:0] SC_P1_B2      = 8'h11;
    localparam logic [7:0] SC_P1_B3      = 8'h29;
    localparam logic [7:0] SC_P1_START   = 8'h16;
    localparam logic [7:0] SC_P1_COIN    = 8'h2E;
    localparam logic [7:0] SC_P1_PAUSE   = 8'h4D;
    localparam logic [7:0] SC_SERVICE1   = 8'h46;

    // Player 2 scancodes (player 2 pause has no key)
    localparam logic [7:0] SC_P2_UP      = 8'h2D;
    localparam logic [7:0] SC_P2_DOWN    = 8'h2B;
    localparam logic [7:0] SC_P2_LEFT    = 8'h23;
    localparam logic [7:0] SC_P2_RIGHT   = 8'h34;
    localparam logic [7:0] SC_P2_B1      = 8'h1C;
    localparam logic [7:0] SC_P2_B2      = 8'h1B;
    localparam logic [7:0] SC_P2_B3      = 8'h15;
    localparam logic [7:0] SC_P2_START   = 8'h1E;
    localparam logic [7:0] SC_P2_COIN    = 8'h36;
    localparam logic [7:0] SC_SERVICE2   = 8'h45;

    typedef struct packed {
        logic       valid;
        logic       player;   // 0 = player 1, 1 = player 2
        logic [3:0] bit_idx;  // joystick bit position
    } key_target_t;

    function automatic key_target_t mk_target(input logic player, input logic [3:0] idx);
        key_target_t t;
        t.valid   = 1'b1;
        t.player  = player;
        t.bit_idx = idx;
        return t;
    endfunction

    // Unknown scancodes decode to valid = 0 and are dropped by the caller.
    function automatic key_target_t decode_scancode(input logic [7:0] code);
        key_target_t t;
        t = '0;
        case (code)
            SC_P1_UP:    t = mk_target(1'b0, JB_UP);
            SC_P1_DOWN:  t = mk_target(1'b0, JB_DOWN);
            SC_P1_LEFT:  t = mk_target(1'b0, JB_LEFT);
            SC_P1_RIGHT: t = mk_target(1'b0, JB_RIGHT);
            SC_P1_B1:    t = mk_target(1'b0, JB_B1);
            SC_P1_B2:    t = mk_target(1'b0, JB_B2);
            SC_P1_B3:    t = mk_target(1'b0, JB_B3);
            SC_P1_START: t = mk_target(1'b0, JB_START);
            SC_P1_COIN:  t = mk_target(1'b0, JB_COIN);
            SC_P1_PAUSE: t = mk_target(1'b0, JB_PAUSE);
            SC_SERVICE1: t = mk_target(1'b0, JB_SERVICE);
            SC_P2_UP:    t = mk_target(1'b1, JB_UP);
            SC_P2_DOWN:  t = mk_target(1'b1, JB_DOWN);
            SC_P2_LEFT:  t = mk_target(1'b1, JB_LEFT);
            SC_P2_RIGHT: t = mk_target(1'b1, JB_RIGHT);
            SC_P2_B1:    t = mk_target(1'b1, JB_B1);
            SC_P2_B2:    t = mk_target(1'b1, JB_B2);
            SC_P2_B3:    t = mk_target(1'b1, JB_B3);
            SC_P2_START: t = mk_target(1'b1, JB_START);
            SC_P2_COIN:  t = mk_target(1'b1, JB_COIN);
            SC_SERVICE2: t = mk_target(1'b1, JB_SERVICE);
            default:     t = '0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/input_ctrl_coin_pulse.sv
// ---------------------------------------------------------------------------
// coin_pulse
// Turns a coin source level into a fixed-length coin pulse. A 0->1 edge of
// src_i while idle loads a down-counter; coin_o is high while the counter is
// non-zero, i.e. for exactly COIN_PULSE cycles starting one cycle after the
// edge. Edges during an active pulse are ignored; since the edge register
// keeps tracking the source, a source held high never retriggers.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset (kills an active pulse at once)
//   src_i  : coin source level (key flag OR joystick bit)
//   coin_o : coin pulse output
// ---------------------------------------------------------------------------
module coin_pulse #(
    parameter logic [23:0] COIN_PULSE = 24'd960000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic src_i,
    output logic coin_o
);

    // A zero length would never produce a pulse; stretch it to one cycle.
    localparam logic [23:0] PULSE_LEN = (COIN_PULSE == 24'd0) ? 24'd1 : COIN_PULSE;

    logic        src_q;
    logic [23:0] cnt_q;
    logic [23:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != 24'd0) begin
            cnt_d = cnt_q - 24'd1;
        end else if (src_i && !src_q) begin
            cnt_d = PULSE_LEN;
        end
    end

    // src_q resets to 0 so a source already high leaving reset is an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q <= 1'b0;
            cnt_q <= 24'd0;
        end else begin
            src_q <= src_i;
            cnt_q <= cnt_d;
        end
    end

    assign coin_o = (cnt_q != 24'd0);

endmodule

// File: rtl/input_ctrl.sv
// ---------------------------------------------------------------------------
// input_ctrl
// Merges PS/2 keyboard keys and two joysticks into per-player arcade inputs.
// Keyboard events set/clear key flags (one cycle), flags are ORed with the
// joystick words and registered (one more cycle). Coin outputs are fixed
// length pulses, pause outputs toggle on each source rising edge.
//   clk                    : system clock
//   rst_n                  : asynchronous active-low reset
//   ps2_key[10:0]          : [10] event toggle, [9] pressed, [7:0] scancode
//   joystick_0/1[10:0]     : [0]R [1]L [2]D [3]U [6:4]B3..B1 [7]start
//                            [8]coin [9]pause [10]service
//   p1_dir/p2_dir[3:0]     : {up,down,left,right}
//   p1_buttons/p2_buttons  : {B3,B2,B1}
//   p1/p2_start, p1/p2_coin, p1/p2_pause, service1/2 : single bits
// ---------------------------------------------------------------------------
module input_ctrl
    import input_pkg::*;
#(
    parameter logic [23:0] COIN_PULSE = 24'd960000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] ps2_key,
    input  logic [10:0] joystick_0,
    input  logic [10:0] joystick_1,
    output logic [3:0]  p1_dir,
    output logic [3:0]  p2_dir,
    output logic [2:0]  p1_buttons,
    output logic [2:0]  p2_buttons,
    output logic        p1_start,
    output logic        p2_start,
    output logic        p1_coin,
    output logic        p2_coin,
    output logic        p1_pause,
    output logic        p2_pause,
    output logic        service1,
    output logic        service2
);

    // History of the PS/2 event toggle. Deliberately not reset: it keeps
    // following ps2_key[10] during reset so a toggle that happened while
    // reset was asserted is not seen as an event afterwards.
    logic ps2_tog_q;

    always_ff @(posedge clk) begin
        ps2_tog_q <= ps2_key[10];
    end

    logic        ps2_event;
    key_target_t key_tgt;

    assign ps2_event = (ps2_key[10] != ps2_tog_q);
    assign key_tgt   = decode_scancode(ps2_key[7:0]);

    // Key flags in joystick layout, index [player][bit].
    logic [1:0][JOY_W-1:0] key_q;
    logic [1:0][JOY_W-1:0] key_d;

    always_comb begin
        key_d = key_q;
        if (ps2_event && key_tgt.valid) begin
            key_d[key_tgt.player][key_tgt.bit_idx] = ps2_key[9];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q <= '0;
        end else begin
            key_q <= key_d;
        end
    end

    // Per-player source words and registered outputs
    logic [JOY_W-1:0] joy        [2];
    logic [JOY_W-1:0] src        [2];
    logic [3:0]       dir_q      [2];
    logic [2:0]       btn_q      [2];
    logic             start_q    [2];
    logic             service_q  [2];
    logic             pause_src_q[2];
    logic             pause_q    [2];
    logic             coin       [2];

    assign joy[0] = joystick_0;
    // Player 2 pause has no key; its key flag is never written.
    assign joy[1] = joystick_1;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_player
            assign src[gi] = key_q[gi] | joy[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dir_q[gi]       <= 4'd0;
                    btn_q[gi]       <= 3'd0;
                    start_q[gi]     <= 1'b0;
                    service_q[gi]   <= 1'b0;
                    pause_src_q[gi] <= 1'b0;
                    pause_q[gi]     <= 1'b0;
                end else begin
                    // {up,down,left,right} and {B3,B2,B1} are straight slices
                    // of the joystick layout; opposite directions pass as-is.
                    dir_q[gi]       <= src[gi][JB_UP:JB_RIGHT];
                    btn_q[gi]       <= src[gi][JB_B3:JB_B1];
                    start_q[gi]     <= src[gi][JB_START];
                    service_q[gi]   <= src[gi][JB_SERVICE];
                    pause_src_q[gi] <= src[gi][JB_PAUSE];
                    if (src[gi][JB_PAUSE] && !pause_src_q[gi]) begin
                        pause_q[gi] <= !pause_q[gi];
                    end
                end
            end

            coin_pulse #(
                .COIN_PULSE(COIN_PULSE)
            ) u_coin_pulse (
                .clk   (clk),
                .rst_n (rst_n),
                .src_i (src[gi][JB_COIN]),
                .coin_o(coin[gi])
            );
        end
    endgenerate

    assign p1_dir     = dir_q[0];
    assign p2_dir     = dir_q[1];
    assign p1_buttons = btn_q[0];
    assign p2_buttons = btn_q[1];
    assign p1_start   = start_q[0];
    assign p2_start   = start_q[1];
    assign p1_coin    = coin[0];
    assign p2_coin    = coin[1];
    assign p1_pause   = pause_q[0];
    assign p2_pause   = pause_q[1];
    assign service1   = service_q[0];
    assign service2   = service_q[1];

endmodule

// File: tb/tb_input_ctrl.sv
// ---------------------------------------------------------------------------
// tb_input_ctrl
// Self-checking bench for input_ctrl (COIN_PULSE = 8). A reference model
// keeps a pressed[] table indexed by scancode plus a scancode map per
// player, and models coin/pause behaviour with plain counters. Inputs are
// driven on the falling edge, the model advances on the rising edge and
// outputs are compared on the following falling edge.
// ---------------------------------------------------------------------------
module tb_input_ctrl;

    localparam logic [23:0] CP = 24'd8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] ps2_key = '0;
    logic [10:0] joystick_0 = '0;
    logic [10:0] joystick_1 = '0;
    logic [3:0]  p1_dir, p2_dir;
    logic [2:0]  p1_buttons, p2_buttons;
    logic        p1_start, p2_start, p1_coin, p2_coin;
    logic        p1_pause, p2_pause, service1, service2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    input_ctrl #(.COIN_PULSE(CP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_key   (ps2_key),
        .joystick_0(joystick_0),
        .joystick_1(joystick_1),
        .p1_dir    (p1_dir),
        .p2_dir    (p2_dir),
        .p1_buttons(p1_buttons),
        .p2_buttons(p2_buttons),
        .p1_start  (p1_start),
        .p2_start  (p2_start),
        .p1_coin   (p1_coin),
        .p2_coin   (p2_coin),
        .p1_pause  (p1_pause),
        .p2_pause  (p2_pause),
        .service1  (service1),
        .service2  (service2)
    );

    // ---------------- reference model ----------------
    bit          pressed   [256];
    logic [7:0]  map_code  [2][11];   // 8'h00 = no key for that bit
    bit          prev_tog;
    int          coin_rem  [2];
    bit          coin_prev [2];
    bit          pause_st  [2];
    bit          pause_prev[2];
    logic [21:0] exp_q;

    function automatic logic [21:0] dut_out();
        return {p1_dir, p2_dir, p1_buttons, p2_buttons, p1_start, p2_start,
                p1_coin, p2_coin, p1_pause, p2_pause, service1, service2};
    endfunction

    function automatic void model_reset();
        foreach (pressed[i]) pressed[i] = 1'b0;
        for (int p = 0; p < 2; p++) begin
            coin_rem[p]   = 0;
            coin_prev[p]  = 1'b0;
            pause_st[p]   = 1'b0;
            pause_prev[p] = 1'b0;
        end
        exp_q = '0;
    endfunction

    // Applies one rising edge: outputs reflect sources built from the key
    // state as it was before this edge; a key event lands afterwards.
    function automatic void model_edge();
        logic [10:0] j [2];
        logic [10:0] s [2];
        j[0] = joystick_0;
        j[1] = joystick_1;
        if (!rst_n) begin
            model_reset();
            prev_tog = ps2_key[10];
            return;
        end
        for (int p = 0; p < 2; p++) begin
            for (int b = 0; b < 11; b++) begin
                s[p][b] = j[p][b] | ((map_code[p][b] != 8'h00) && pressed[map_code[p][b]]);
            end
            if (coin_rem[p] > 0)
                coin_rem[p] = coin_rem[p] - 1;
            else if (s[p][8] && !coin_prev[p])
                coin_rem[p] = int'(CP);
            coin_prev[p] = s[p][8];
            if (s[p][9] && !pause_prev[p]) pause_st[p] = !pause_st[p];
            pause_prev[p] = s[p][9];
        end
        exp_q = {s[0][3], s[0][2], s[0][1], s[0][0],
                 s[1][3], s[1][2], s[1][1], s[1][0],
                 s[0][6], s[0][5], s[0][4],
                 s[1][6], s[1][5], s[1][4],
                 s[0][7], s[1][7],
                 (coin_rem[0] > 0), (coin_rem[1] > 0),
                 pause_st[0], pause_st[1],
                 s[0][10], s[1][10]};
        if (ps2_key[10] != prev_tog) pressed[ps2_key[7:0]] = ps2_key[9];
        prev_tog = ps2_key[10];
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic send_key(input logic [7:0] code, input logic press);
        ps2_key = {~ps2_key[10], press, 1'b0, code};
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (dut_out() !== 22'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", dut_out(), 22'h0);
        end
        rst_n = 1'b1;
        repeat (2) begin
            tick();
            checks++;
            if (dut_out() !== exp_q) begin
                errors++;
                $display("FAIL reset_idle: got %h expected %h", dut_out(), exp_q);
            end
        end
    endtask

    task automatic test_key_dir();
        logic [3:0] want [4];
        want[0] = 4'b0000; want[1] = 4'b1000; want[2] = 4'b1000; want[3] = 4'b0000;
        for (int k = 0; k < 2; k++) begin
            send_key(8'h75, (k == 0));
            for (int c = 0; c < 2; c++) begin
                tick();
                checks++;
                if (p1_dir !== want[k * 2 + c]) begin
                    errors++;
                    $display("FAIL key_dir k%0d c%0d: got %b expected %b", k, c, p1_dir, want[k * 2 + c]);
                end
                checks++;
                if (dut_out() !== exp_q) begin
                    errors++;
                    $display("FAIL key_dir_model: got %h expected %h", dut_out(), exp_q);
                end
            end
        end
    endtask

    task automatic test_buttons();
        int high = 0;
        joystick_1[5] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c == 3) joystick_1[5] = 1'b0;
            tick();
            if (p2_buttons == 3'b010) high++;
            checks++;
            if (p2_buttons !== ((c < 3) ? 3'b010 : 3'b000)) begin
                errors++;
                $display("FAIL buttons c%0d: got %b expected %b", c, p2_buttons, (c < 3) ? 3'b010 : 3'b000);
            end
        end
        checks++;
        if (high != 3) begin
            errors++;
            $display("FAIL buttons_len: got %0d expected 3", high);
        end
    endtask

    task automatic test_coin_hold();
        int high = 0;
        joystick_0[8] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (p1_coin) high++;
            checks++;
            if (dut_out() !== exp_q) begin
                errors++;
                $display("FAIL coin_hold_model c%0d: got %h expected %h", c, dut_out(), exp_q);
            end
        end
        checks++;
        if (high != 8) begin
            errors++;
            $display("FAIL coin_hold_len: got %0d expected 8", high);
        end
        joystick_0[8] = 1'b0;
        tick();
        checks++;
        if (p1_coin !== 1'b0) begin
            errors++;
            $display("FAIL coin_no_retrigger: got %b expected 0", p1_coin);
        end
    endtask

    task automatic test_coin_retrig();
        int high = 0;
        // cycle n = n-th tick after the first rising edge
        for (int c = 1; c <= 12; c++) begin
            joystick_0[8] = (c == 1 || c == 4 || c == 12);
            tick();
            if (c <= 11 && p1_coin) high++;
            checks++;
            if (dut_out() !== exp_q) begin
                errors++;
                $display("FAIL coin_retrig_model c%0d: got %h expected %h", c, dut_out(), exp_q);
            end
        end
        checks++;
        if (high != 8) begin
            errors++;
            $display("FAIL coin_retrig_len: got %0d expected 8", high);
        end
        checks++;
        if (p1_coin !== 1'b1) begin
            errors++;
            $display("FAIL coin_second_pulse: got %b expected 1", p1_coin);
        end
        joystick_0[8] = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_pause();
        logic want [4];
        want[0] = 1'b1; want[1] = 1'b1; want[2] = 1'b0; want[3] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send_key(8'h4D, (k % 2 == 0));
            tick();
            tick();
            checks++;
            if (p1_pause !== want[k] || p2_pause !== 1'b0) begin
                errors++;
                $display("FAIL pause k%0d: got p1=%b p2=%b expected p1=%b p2=0", k, p1_pause, p2_pause, want[k]);
            end
        end
    endtask

    task automatic test_reset_mid_pulse();
        joystick_0[8] = 1'b1;
        repeat (3) tick();
        checks++;
        if (p1_coin !== 1'b1) begin
            errors++;
            $display("FAIL mid_pulse_pre: got %b expected 1", p1_coin);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (p1_coin !== 1'b0) begin
            errors++;
            $display("FAIL mid_pulse_async: got %b expected 0", p1_coin);
        end
        tick();
        send_key(8'h75, 1'b1);   // toggle while in reset: must be stale
        repeat (2) tick();
        rst_n = 1'b1;            // coin source still high: edge out of reset
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (p1_dir !== 4'b0000 || (c == 0 && p1_coin !== 1'b1)) begin
                errors++;
                $display("FAIL after_reset c%0d: got dir=%b coin=%b expected dir=0000", c, p1_dir, p1_coin);
            end
            checks++;
            if (dut_out() !== exp_q) begin
                errors++;
                $display("FAIL after_reset_model: got %h expected %h", dut_out(), exp_q);
            end
        end
        joystick_0[8] = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_random();
        logic [7:0] codes [21];
        int n = 0;
        for (int p = 0; p < 2; p++)
            for (int b = 0; b < 11; b++)
                if (map_code[p][b] != 8'h00) begin
                    codes[n] = map_code[p][b];
                    n++;
                end
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(3) == 0) begin
                int b = $urandom_range(21);
                if (b < 11) joystick_0[b] = ~joystick_0[b];
                else joystick_1[b - 11] = ~joystick_1[b - 11];
            end
            if ($urandom_range(2) == 0) begin
                logic [7:0] code;
                code = ($urandom_range(4) == 0) ? 8'($urandom) : codes[$urandom_range(20)];
                send_key(code, 1'($urandom));
            end
            tick();
            checks++;
            if (dut_out() !== exp_q) begin
                errors++;
                $display("FAIL random c%0d: got %h expected %h", c, dut_out(), exp_q);
            end
        end
        joystick_0 = '0;
        joystick_1 = '0;
        repeat (12) tick();
    endtask

    initial begin
        logic [7:0] m0 [11];
        logic [7:0] m1 [11];
        m0 = '{8'h74, 8'h6B, 8'h72, 8'h75, 8'h14, 8'h11, 8'h29, 8'h16, 8'h2E, 8'h4D, 8'h46};
        m1 = '{8'h34, 8'h23, 8'h2B, 8'h2D, 8'h1C, 8'h1B, 8'h15, 8'h1E, 8'h36, 8'h00, 8'h45};
        for (int b = 0; b < 11; b++) begin
            map_code[0][b] = m0[b];
            map_code[1][b] = m1[b];
        end
        model_reset();
        prev_tog = 1'b0;
        @(negedge clk);
        test_reset();
        test_key_dir();
        test_buttons();
        test_coin_hold();
        test_coin_retrig();
        test_pause();
        test_reset_mid_pulse();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/input_ctrl.md
INPUT_CTRL -- requirements
Module: input_ctrl

Interface
REQ-001 SHALL have parameter COIN_PULSE, default 24'd960000: coin output high time, in clk cycles.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ps2_key  input  11  [10]=event toggle, [9]=pressed, [7:0]=scancode.
REQ-005 SHALL have port joystick_0  input  11  player 1 pad: [0]R [1]L [2]D [3]U [6:4]B3..B1 [7]start [8]coin [9]pause [10]service.
REQ-006 SHALL have port joystick_1  input  11  player 2 pad, same layout.
REQ-007 SHALL have ports p1_dir, p2_dir  output  4  {up,down,left,right}.
REQ-008 SHALL have ports p1_buttons, p2_buttons  output  3  {B3,B2,B1}.
REQ-009 SHALL have ports p1_start, p2_start, p1_coin, p2_coin, p1_pause, p2_pause, service1, service2  output  1 each.

Function
REQ-010 SHALL register ps2_key[10] each cycle; an event occurs when the sampled ps2_key[10] differs from the registered value.
REQ-011 On an event, SHALL load ps2_key[9] into the key flag matching ps2_key[7:0]; unknown scancodes SHALL be ignored.
REQ-012 Key map P1: 75 up, 72 down, 6B left, 74 right, 14 B1, 11 B2, 29 B3, 16 start, 2E coin, 4D pause, 46 service1.
REQ-013 Key map P2: 2D up, 2B down, 23 left, 34 right, 1C B1, 1B B2, 15 B3, 1E start, 36 coin, 45 service2; P2 pause has no key.
REQ-014 Each source SHALL be key flag OR matching joystick bit.
REQ-015 Direction, button, start and service outputs SHALL be registered copies of their sources.
REQ-016 Latency SHALL be 1 cycle from a joystick bit change and 2 cycles from a ps2_key[10] toggle.
REQ-017 Each coin output SHALL go high 1 cycle after a rising edge of its source and stay high exactly COIN_PULSE cycles, whatever the source does meanwhile.
REQ-018 A coin rising edge while that coin pulse is active SHALL be ignored.
REQ-019 A new coin pulse SHALL need a fresh 0->1 source edge after the active pulse ends; a source held high SHALL not retrigger.
REQ-020 Each pause output SHALL toggle 1 cycle after each rising edge of its source; holding the source high SHALL not toggle again.
REQ-021 Simultaneous opposite directions SHALL pass through unmodified.
REQ-022 When a keyboard event and a joystick change arrive in the same cycle, both SHALL be applied, each with its own latency.

Reset
REQ-023 While rst_n is low, all outputs, key flags, edge registers, pause toggles and coin counters SHALL be 0, and the ps2_key[10] history register SHALL load ps2_key[10].
REQ-024 After rst_n rises, a stale toggle SHALL not produce an event.
REQ-025 Reset asserted mid coin pulse SHALL end the pulse at once.
REQ-026 After reset, a source already high SHALL count as a rising edge on the first cycle out of reset.

Structure
REQ-027 Scancode constants and joystick bit-index constants SHALL live in shared package input_pkg.
REQ-028 Coin pulse logic SHALL be one sub-module, coin_pulse (edge detect plus down-counter), instantiated once per player.
REQ-029 Coin counter width SHALL be 24 bits; COIN_PULSE = 0 SHALL be treated as 1.

Verification
REQ-030 Toggle ps2_key[10] with pressed=1, code 75 -> p1_dir=4'b1000 two cycles later; repeat with pressed=0 -> 4'b0000.
REQ-031 joystick_1[5]=1 for 3 cycles -> p2_buttons=3'b010 for exactly 3 cycles, delayed by 1.
REQ-032 COIN_PULSE=8, joystick_0[8] high for 20 cycles -> p1_coin high exactly 8 cycles, then no retrigger.
REQ-033 COIN_PULSE=8, second coin rising edge at pulse cycle 4 -> still one 8-cycle pulse; edge at cycle 12 -> second pulse.
REQ-034 Two pause presses via key 4D -> p1_pause goes 0->1->0; p2_pause stays 0.
REQ-035 rst_n low at coin pulse cycle 3, with ps2_key[10] toggled during reset -> p1_coin=0 immediately, no key event after release.
